// File: rtl/jpeg_pkg.sv
// Shared JPEG encoder definitions: block geometry defaults, component tags,
// and the quantizer-control FSM state encoding.
package jpeg_pkg;

  localparam int unsigned MCU_SIZE_DEF      = 8;
  localparam int unsigned QUAN_BITWIDTH_DEF = 16;

  // Colour component carried alongside each 8x8 block
  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  // Quantizer control states
  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } qstate_e;

endpackage

// File: rtl/quant_table_bank.sv
// One quantization table bank: single write port, whole table read in parallel.
// Ports:
//   clk, n_rst : clock, async active-low reset (clears every entry)
//   we         : write strobe
//   addr       : raster index i*MCU_SIZE+j
//   data       : entry value
//   tbl        : full table, tbl[i][j] = entry at raster index i*MCU_SIZE+j
module quant_table_bank
  import jpeg_pkg::*;
#(
  parameter int unsigned MCU_SIZE      = MCU_SIZE_DEF,
  parameter int unsigned QUAN_BITWIDTH = QUAN_BITWIDTH_DEF
) (
  input  logic                                               clk,
  input  logic                                               n_rst,
  input  logic                                               we,
  input  logic [$clog2(MCU_SIZE*MCU_SIZE)-1:0]               addr,
  input  logic [QUAN_BITWIDTH-1:0]                           data,
  output logic [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] tbl
);

  localparam int unsigned N_ENTRY = MCU_SIZE * MCU_SIZE;

  logic [N_ENTRY-1:0][QUAN_BITWIDTH-1:0] mem;

  // Entry storage; out-of-range addresses (non power-of-two sizes) are dropped
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem <= '0;
    end else if (we && (32'(addr) < N_ENTRY)) begin
      mem[addr] <= data;
    end
  end

  // Flat raster order and the 2-D packed view share the same bit layout
  assign tbl = mem;

endmodule

// File: rtl/quant_ctrl.sv
// Quantizer control: holds luma/chroma tables, selects the table for each
// accepted block, tracks the quantizer's 2-cycle latency with tag stages,
// and sequences table reload (CFG) / streaming (RUN) / flush (DRAIN).
// Ports:
//   clk, n_rst          : clock, async active-low reset
//   cfg_req             : request table-load mode (RUN -> DRAIN -> CFG)
//   cfg_we/tbl/addr/data: table entry write, honoured only in CFG
//   cfg_done            : pulse ending table-load mode (CFG -> RUN)
//   s_valid/s_comp      : input block present and its component tag
//   s_ready             : input block accepted this cycle (combinational)
//   m_valid/m_comp      : quantized block present and its tag
//   m_ready             : downstream accepts the output block
//   quan_table          : table driven to the quantizer datapath
//   q_wait              : quantizer pipeline stall (combinational)
//   state_o             : current FSM state
module quant_ctrl
  import jpeg_pkg::*;
#(
  parameter int unsigned MCU_SIZE      = MCU_SIZE_DEF,
  parameter int unsigned QUAN_BITWIDTH = QUAN_BITWIDTH_DEF
) (
  input  logic                                                 clk,
  input  logic                                                 n_rst,
  input  logic                                                 cfg_req,
  input  logic                                                 cfg_we,
  input  logic                                                 cfg_tbl,
  input  logic [$clog2(MCU_SIZE*MCU_SIZE)-1:0]                 cfg_addr,
  input  logic [QUAN_BITWIDTH-1:0]                             cfg_data,
  input  logic                                                 cfg_done,
  input  logic                                                 s_valid,
  input  logic [1:0]                                           s_comp,
  output logic                                                 s_ready,
  output logic                                                 m_valid,
  output logic [1:0]                                           m_comp,
  input  logic                                                 m_ready,
  output logic [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] quan_table,
  output logic                                                 q_wait,
  output logic [1:0]                                           state_o
);

  qstate_e    state;
  logic       v1, v2;
  logic [1:0] c1, c2;
  logic       adv;
  logic       luma_we, chroma_we;

  logic [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] luma_tbl;
  logic [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] chroma_tbl;

  // Pipeline advances unless a valid output is being back-pressured
  assign adv     = !(v2 && !m_ready);
  assign q_wait  = !adv;
  assign s_ready = adv && (state == ST_RUN);
  assign m_valid = v2;
  assign m_comp  = c2;
  assign state_o = state;

  // Writes only land while in CFG, including the cycle carrying cfg_done
  assign luma_we   = cfg_we && (state == ST_CFG) && !cfg_tbl;
  assign chroma_we = cfg_we && (state == ST_CFG) &&  cfg_tbl;

  quant_table_bank #(
    .MCU_SIZE      (MCU_SIZE),
    .QUAN_BITWIDTH (QUAN_BITWIDTH)
  ) u_luma_bank (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (luma_we),
    .addr  (cfg_addr),
    .data  (cfg_data),
    .tbl   (luma_tbl)
  );

  quant_table_bank #(
    .MCU_SIZE      (MCU_SIZE),
    .QUAN_BITWIDTH (QUAN_BITWIDTH)
  ) u_chroma_bank (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (chroma_we),
    .addr  (cfg_addr),
    .data  (cfg_data),
    .tbl   (chroma_tbl)
  );

  // Mode sequencing; DRAIN waits until both tag stages are empty
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_CFG;
    end else begin
      case (state)
        ST_CFG:   if (cfg_done)   state <= ST_RUN;
        ST_RUN:   if (cfg_req)    state <= ST_DRAIN;
        ST_DRAIN: if (!v1 && !v2) state <= ST_CFG;
        default:                  state <= ST_CFG;
      endcase
    end
  end

  // Latency-matching tag stages; all hold while stalled
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      c1 <= '0;
      c2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      c2 <= c1;
      v1 <= s_valid && s_ready;
      c1 <= s_comp;
    end
  end

  // Table presented to the quantizer; anything other than Y uses chroma
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      quan_table <= '0;
    end else if (s_valid && adv) begin
      quan_table <= (s_comp == COMP_Y) ? luma_tbl : chroma_tbl;
    end
  end

endmodule

// File: tb/tb_quant_ctrl.sv
// Directed bench for quant_ctrl: reset behaviour, table load, streaming,
// back-pressure, drain-to-config and mid-flight reset.
module tb_quant_ctrl;

  localparam int unsigned MS = 8;
  localparam int unsigned QW = 16;

  logic                             clk;
  logic                             n_rst;
  logic                             cfg_req;
  logic                             cfg_we;
  logic                             cfg_tbl;
  logic [5:0]                       cfg_addr;
  logic [QW-1:0]                    cfg_data;
  logic                             cfg_done;
  logic                             s_valid;
  logic [1:0]                       s_comp;
  logic                             s_ready;
  logic                             m_valid;
  logic [1:0]                       m_comp;
  logic                             m_ready;
  logic [MS-1:0][MS-1:0][QW-1:0]    quan_table;
  logic                             q_wait;
  logic [1:0]                       state_o;

  logic [MS-1:0][MS-1:0][QW-1:0]    exp_luma, exp_chroma, exp_zero;

  int checks = 0;
  int errors = 0;

  quant_ctrl #(.MCU_SIZE(MS), .QUAN_BITWIDTH(QW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .cfg_req    (cfg_req),
    .cfg_we     (cfg_we),
    .cfg_tbl    (cfg_tbl),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_done   (cfg_done),
    .s_valid    (s_valid),
    .s_comp     (s_comp),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_comp     (m_comp),
    .m_ready    (m_ready),
    .quan_table (quan_table),
    .q_wait     (q_wait),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; cfg_req = 0; cfg_we = 0; cfg_tbl = 0; cfg_addr = '0;
    cfg_data = '0; cfg_done = 0; s_valid = 0; s_comp = '0; m_ready = 1;
    #12;
    n_rst = 1'b1;
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
      checks++; if (q_wait !== 1'b0)  begin errors++; $display("FAIL reset_q_wait got=%b exp=0", q_wait); end
      checks++; if (m_comp !== 2'd0)  begin errors++; $display("FAIL reset_m_comp got=%0d exp=0", m_comp); end
      checks++; if (quan_table !== exp_zero) begin errors++; $display("FAIL reset_quan_table got=%h exp=0", quan_table[0][0]); end
      step();
    end
    s_valid = 1'b0;
  endtask

  // Load luma=0x0100, chroma=0x0080; last write shares its cycle with cfg_done
  task automatic test_load();
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < 64; a++) begin
        cfg_we   = 1'b1;
        cfg_tbl  = t[0];
        cfg_addr = 6'(a);
        cfg_data = (t == 0) ? 16'h0100 : 16'h0080;
        cfg_done = (t == 1 && a == 63);
        #1;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL load_state got=%0d exp=0", state_o); end
        step();
      end
    end
    cfg_we = 1'b0; cfg_done = 1'b0;
    #1;
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL load_to_run got=%0d exp=1", state_o); end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    s_valid = 1'b1; s_comp = 2'd0; #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready0 got=%b exp=1", s_ready); end
    step();
    s_comp = 2'd1; #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready1 got=%b exp=1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_latency got=%b exp=0", m_valid); end
    checks++; if (quan_table !== exp_luma) begin errors++; $display("FAIL b2b_tbl_y got=%h exp=0100", quan_table[0][0]); end
    step();
    s_comp = 2'd2; #1;
    checks++; if (m_valid !== 1'b1 || m_comp !== 2'd0) begin errors++; $display("FAIL b2b_out_y got=%b/%0d exp=1/0", m_valid, m_comp); end
    checks++; if (quan_table !== exp_chroma) begin errors++; $display("FAIL b2b_tbl_cb got=%h exp=0080", quan_table[7][7]); end
    step();
    s_valid = 1'b0; #1;
    checks++; if (m_valid !== 1'b1 || m_comp !== 2'd1) begin errors++; $display("FAIL b2b_out_cb got=%b/%0d exp=1/1", m_valid, m_comp); end
    step();
    checks++; if (m_valid !== 1'b1 || m_comp !== 2'd2) begin errors++; $display("FAIL b2b_out_cr got=%b/%0d exp=1/2", m_valid, m_comp); end
    checks++; if (quan_table !== exp_chroma) begin errors++; $display("FAIL b2b_tbl_hold got=%h exp=0080", quan_table[0][0]); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_stall();
    m_ready = 1'b1;
    s_valid = 1'b1; s_comp = 2'd0; step();
    s_comp = 2'd1; step();
    s_comp = 2'd2; m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (q_wait !== 1'b1)  begin errors++; $display("FAIL stall_q_wait got=%b exp=1", q_wait); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready got=%b exp=0", s_ready); end
      checks++; if (m_valid !== 1'b1 || m_comp !== 2'd0) begin errors++; $display("FAIL stall_hold got=%b/%0d exp=1/0", m_valid, m_comp); end
      step();
    end
    m_ready = 1'b1; #1;
    checks++; if (s_ready !== 1'b1 || q_wait !== 1'b0) begin errors++; $display("FAIL stall_release got=%b/%b exp=1/0", s_ready, q_wait); end
    checks++; if (m_comp !== 2'd0) begin errors++; $display("FAIL stall_out0 got=%0d exp=0", m_comp); end
    step();
    s_valid = 1'b0; #1;
    checks++; if (m_valid !== 1'b1 || m_comp !== 2'd1) begin errors++; $display("FAIL stall_out1 got=%b/%0d exp=1/1", m_valid, m_comp); end
    step();
    checks++; if (m_valid !== 1'b1 || m_comp !== 2'd2) begin errors++; $display("FAIL stall_out2 got=%b/%0d exp=1/2", m_valid, m_comp); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup got=%b exp=0", m_valid); end
  endtask

  task automatic test_drain();
    m_ready = 1'b1;
    s_valid = 1'b1; s_comp = 2'd1; step();
    s_comp = 2'd2; cfg_req = 1'b1; step();
    s_valid = 1'b0; cfg_req = 1'b0;
    cfg_we = 1'b1; cfg_tbl = 1'b0; cfg_addr = 6'd0; cfg_data = 16'hDEAD; #1;
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL drain_state got=%0d exp=2", state_o); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL drain_s_ready got=%b exp=0", s_ready); end
    checks++; if (m_valid !== 1'b1 || m_comp !== 2'd1) begin errors++; $display("FAIL drain_out0 got=%b/%0d exp=1/1", m_valid, m_comp); end
    step();
    cfg_tbl = 1'b1; cfg_addr = 6'd63; cfg_data = 16'hBEEF; #1;
    checks++; if (m_valid !== 1'b1 || m_comp !== 2'd2) begin errors++; $display("FAIL drain_out1 got=%b/%0d exp=1/2", m_valid, m_comp); end
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL drain_hold got=%0d exp=2", state_o); end
    step();
    cfg_we = 1'b0; #1;
    checks++; if (m_valid !== 1'b0 || state_o !== 2'd2) begin errors++; $display("FAIL drain_last got=%b/%0d exp=0/2", m_valid, state_o); end
    step();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL drain_to_cfg got=%0d exp=0", state_o); end
    cfg_done = 1'b1; step();
    cfg_done = 1'b0;
    s_valid = 1'b1; s_comp = 2'd0; step();
    s_comp = 2'd3; #1;
    checks++; if (quan_table !== exp_luma) begin errors++; $display("FAIL drain_luma_kept got=%h exp=0100", quan_table[0][0]); end
    step();
    s_valid = 1'b0; #1;
    checks++; if (quan_table !== exp_chroma) begin errors++; $display("FAIL comp3_chroma got=%h exp=0080", quan_table[7][7]); end
    repeat (3) step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_idle got=%b exp=0", m_valid); end
  endtask

  task automatic test_mid_reset();
    m_ready = 1'b1;
    s_valid = 1'b1; s_comp = 2'd0; step();
    s_comp = 2'd1; step();
    s_valid = 1'b0; #1;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b exp=1", m_valid); end
    #2; n_rst = 1'b0; #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_async got=%b exp=0", m_valid); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL mid_state got=%0d exp=0", state_o); end
    checks++; if (quan_table !== exp_zero) begin errors++; $display("FAIL mid_tbl got=%h exp=0", quan_table[0][0]); end
    step();
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL mid_after got=%b/%b exp=0/0", m_valid, s_ready); end
    end
  endtask

  initial begin
    for (int i = 0; i < MS; i++) begin
      for (int j = 0; j < MS; j++) begin
        exp_luma[i][j]   = 16'h0100;
        exp_chroma[i][j] = 16'h0080;
        exp_zero[i][j]   = 16'h0000;
      end
    end
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_drain();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quant_ctrl.md
QUANT_CTRL -- requirements
Module: quant_ctrl

Interface
REQ-001 SHALL have parameter MCU_SIZE, default 8, block edge length in coefficients.
REQ-002 SHALL have parameter QUAN_BITWIDTH, default 16, width of one quantization-table entry (reciprocal, fixed point).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_req  input  1  request to enter table-load mode.
REQ-006 SHALL have port cfg_we  input  1  write one table entry.
REQ-007 SHALL have port cfg_tbl  input  1  table select: 0 = luma, 1 = chroma.
REQ-008 SHALL have port cfg_addr  input  $clog2(MCU_SIZE*MCU_SIZE)  raster index, i*MCU_SIZE+j.
REQ-009 SHALL have port cfg_data  input  QUAN_BITWIDTH  entry value.
REQ-010 SHALL have port cfg_done  input  1  one-cycle pulse ending table-load mode.
REQ-011 SHALL have port s_valid  input  1  DCT block present at quantizer input.
REQ-012 SHALL have port s_comp  input  2  component tag: 0 = Y, 1 = Cb, 2 = Cr.
REQ-013 SHALL have port s_ready  output  1  block accepted this cycle when s_valid is also 1.
REQ-014 SHALL have port m_valid  output  1  quantized block valid at quantizer output.
REQ-015 SHALL have port m_comp  output  2  tag of the block on m_valid.
REQ-016 SHALL have port m_ready  input  1  downstream accepts the block.
REQ-017 SHALL have port quan_table  output  [MCU_SIZE][MCU_SIZE][QUAN_BITWIDTH]  table driven to the quantizer.
REQ-018 SHALL have port q_wait  output  1  stall for the quantizer pipeline.
REQ-019 SHALL have port state_o  output  2  current FSM state, for debug.

Function
REQ-020 SHALL model the quantizer's 2-cycle latency with tag stages (v1,c1) and (v2,c2); m_valid=v2 and m_comp=c2.
REQ-021 SHALL define adv = !(v2 && !m_ready) and drive q_wait = !adv combinationally.
REQ-022 SHALL on adv: v2<=v1, c2<=c1, v1<=s_valid&&s_ready, c1<=s_comp; when adv=0 all tags SHALL hold.
REQ-023 SHALL drive s_ready = adv && (state==RUN).
REQ-024 SHALL drive quan_table from luma bank when s_comp==0, else from chroma bank; s_comp==3 SHALL select chroma.
REQ-025 SHALL hold quan_table at its last-driven value when s_valid=0 or adv=0.
REQ-026 SHALL implement FSM states: CFG (0), RUN (1), DRAIN (2).
REQ-027 SHALL leave reset in CFG; CFG->RUN on cfg_done; RUN->DRAIN on cfg_req; DRAIN->CFG when v1==0 and v2==0.
REQ-028 SHALL accept cfg_we only in CFG; cfg_we in RUN/DRAIN SHALL be ignored.
REQ-029 SHALL give cfg_done priority over a same-cycle cfg_we: the write is still performed.
REQ-030 SHALL in DRAIN keep advancing/stalling per REQ-021, so in-flight blocks complete.
REQ-031 SHALL allow one accepted block per cycle in steady state (m_ready=1 -> no bubbles).

Reset
REQ-032 SHALL on n_rst=0 asynchronously clear v1, v2, c1, c2, both table banks, and the quan_table hold register, and set state=CFG.
REQ-033 SHALL give reset values: s_ready=0, m_valid=0, m_comp=0, q_wait=0, quan_table=0, state_o=0.
REQ-034 SHALL discard in-flight blocks on reset mid-operation; no m_valid after release until a new block is accepted.

Structure
REQ-035 SHALL place the component-tag enum (Y/CB/CR), the FSM state enum, and MCU_SIZE/QUAN_BITWIDTH defaults in the shared jpeg package.
REQ-036 SHALL implement the two table banks as one sub-module quant_table_bank (write port + full parallel read), instantiated once per bank.

Verification
REQ-037 SHALL cover: after reset, s_valid=1 -> s_ready=0, m_valid=0, state_o=0 until cfg_done.
REQ-038 SHALL cover: load luma all 0x0100 and chroma all 0x0080, cfg_done, then Y,Cb,Cr back-to-back with m_ready=1 -> m_valid 2 cycles after each acceptance, m_comp 0,1,2 in order, quan_table 0x0100 for Y and 0x0080 for Cb/Cr.
REQ-039 SHALL cover: m_ready=0 for 3 cycles with v2=1 -> q_wait=1, s_ready=0, m_comp stable, nothing lost or duplicated.
REQ-040 SHALL cover: cfg_req with 2 blocks in flight -> DRAIN, both blocks emitted, then CFG; a cfg_we issued during DRAIN leaves the tables unchanged.
REQ-041 SHALL cover: n_rst asserted with v1=v2=1 -> m_valid=0 immediately; after release no output appears.
